// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two combinational read ports, optional WB->ID bypass under REGFILE_BYPASS_EN
module regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2
);

    localparam int DEPTH = 2 ** AW;

    // Register 0 has no storage; index range starts at 1.
    logic [DW-1:0] regs_q [1:DEPTH-1];
    logic [DW-1:0] regs_d [1:DEPTH-1];

    logic hit1;
    logic hit2;

`ifdef REGFILE_BYPASS_EN
    // Same-cycle WB->ID forwarding; zero-address and reset cases are masked in the read muxes.
    assign hit1 = we && (waddr == raddr1);
    assign hit2 = we && (waddr == raddr2);
`else
    // Without bypass, a read in the write cycle sees the old stored value.
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // Next-state of storage: commit wdata to the addressed register, never to register 0.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (waddr == AW'(i)) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    // Storage registers: synchronous clear on reset, which also suppresses the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: reset, enable and zero address force 0; then bypass; then storage.
    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            if (hit1) begin
                rdata1 = wdata;
            end else begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (raddr1 == AW'(i)) begin
                        rdata1 = regs_q[i];
                    end
                end
            end
        end
    end

    // Read port 2: same priority as port 1, fully independent of it.
    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            if (hit2) begin
                rdata2 = wdata;
            end else begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (raddr2 == AW'(i)) begin
                        rdata2 = regs_q[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - scoreboard bench for regfile against an array-based reference model
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:31];
    int          checks   = 0;
    int          failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic r, input logic re,
                                               input logic [4:0] ra, input logic w,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (r || !re || ra == 5'd0) return 32'h0;
        if (BYP && w && wa == ra) return wd;
        return mem[ra];
    endfunction

    // One cycle: drive inputs after the edge, queue the expected reads, then advance the model.
    task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                        input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        x.e1  = model_read(r, e1, a1, w, wa, wd);
        x.e2  = model_read(r, e2, a2, w, wa, wd);
        x.tag = tag;
        sb.push_back(x);
        if (r) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (w && wa != 5'd0) begin
            mem[wa] = wd;
        end
    endtask

    // Monitor: reads are combinational, so a result is present every cycle; sample mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (rdata1 !== x.e1) begin
                    failures++;
                    $display("FAIL %s rdata1 got=%h exp=%h", x.tag, rdata1, x.e1);
                end
                checks++;
                if (rdata2 !== x.e2) begin
                    failures++;
                    $display("FAIL %s rdata2 got=%h exp=%h", x.tag, rdata2, x.e2);
                end
            end
        end
    end

    initial begin
        int drain;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;

        // reset, with reads and a write attempted while rst is high
        step(1, 1, 5'd4, 32'hCAFEF00D, 1, 5'd4, 1, 5'd4, "reset_rd");
        step(1, 0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd31, "reset_rd2");
        step(0, 0, 5'd0, 32'h0, 1, 5'd4, 1, 5'd4, "reset_wr_suppressed");

        // write r5, clear with reset, read back zero
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 5'd0, "wr_r5");
        step(0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5, "rd_r5");
        step(1, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5, "rst_rd_r5");
        step(0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5, "rd_r5_cleared");

        // write then read on both ports
        step(0, 1, 5'd7, 32'h12345678, 0, 5'd0, 0, 5'd0, "wr_r7");
        step(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd7, "rd_r7");

        // zero register, including a pending write to 0
        step(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0, "wr_r0");
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, "rd_r0");

        // read enable
        step(0, 1, 5'd3, 32'hA5A5A5A5, 0, 5'd0, 0, 5'd0, "wr_r3");
        step(0, 0, 5'd0, 32'h0, 1, 5'd3, 0, 5'd3, "re2_off");
        step(0, 0, 5'd0, 32'h0, 0, 5'd3, 1, 5'd3, "re2_on");

        // same-cycle read-after-write
        step(0, 1, 5'd9, 32'h11111111, 0, 5'd0, 0, 5'd0, "wr_r9");
        step(0, 1, 5'd9, 32'h22222222, 1, 5'd9, 1, 5'd3, "raw_r9");
        step(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd9, "raw_r9_next");

        // full sweep
        for (int i = 1; i < 32; i++) begin
            step(0, 1, 5'(i), 32'h01010101 * i, 0, 5'd0, 0, 5'd0, "sweep_wr");
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i), "sweep_rd");
            step(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(31 - i), "sweep_rd_x");
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), 5'($urandom_range(31)), $urandom,
                 ($urandom_range(3) != 0), 5'($urandom_range(31)),
                 ($urandom_range(3) != 0), 5'($urandom_range(31)), "random");
        end

        drain = 0;
        while (sb.size() > 0 && drain < 100) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
